ladybird_uart_tx_arbiter: RTL and testbench

Shares one ladybird UART transmitter between N_REQ byte-stream requesters. Arbitrates round-robin at packet boundaries, so a granted requester owns the transmitter until its byte flagged `last` is accepted. Sits between the on-chip message sources (debug console, status reporter, etc.) and the transmitter's valid/data/ready input.

---
 rtl/ladybird_uart_pkg.sv | 14 +
 rtl/ladybird_rr_pick.sv | 32 +++
 rtl/ladybird_uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_ladybird_uart_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ladybird_uart_pkg.sv
// Shared types for the ladybird UART transmit path: byte type, arbiter states
// and the stall-counter width used by the optional forced-release timer.
package ladybird_uart_pkg;

   typedef logic [7:0] uart_byte_t;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   localparam int UART_ARB_TIMEOUT_W = 16;

endpackage

// File: rtl/ladybird_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, with
// wrap. Generic so other shared resources can reuse it.
module ladybird_rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] onehot,
   output logic [W-1:0] idx,
   output logic         found
);

   logic [W-1:0] slot;

   // Walk the ring starting at ptr; the first hit wins and masks later ones.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      slot   = '0;
      for (int k = 0; k < N; k++) begin
         slot = W'((int'(ptr) + k) % N);
         if (!found && req[slot]) begin
            found        = 1'b1;
            onehot[slot] = 1'b1;
            idx          = slot;
         end
      end
   end

endmodule

// File: rtl/ladybird_uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmitter between N_REQ
// byte streams. Optional forced release of stalled owners: LADYBIRD_UART_ARB_TIMEOUT_EN.
module ladybird_uart_tx_arbiter
   import ladybird_uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter logic [UART_ARB_TIMEOUT_W-1:0] IDLE_TIMEOUT = 16'hFFFF
) (
   input  logic                                          clk,
   input  logic                                          arst,
   input  logic [N_REQ-1:0]                              req_valid,
   input  logic [8*N_REQ-1:0]                            req_data,
   input  logic [N_REQ-1:0]                              req_last,
   output logic [N_REQ-1:0]                              req_ready,
   output logic                                          tx_valid,
   output logic [7:0]                                    tx_data,
   input  logic                                          tx_ready,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]  grant_id,
   output logic                                          busy,
   output logic                                          timeout
);

   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t       state;
   logic [GW-1:0]    rr_ptr;
   logic [N_REQ-1:0] grant_oh;
   uart_byte_t       req_bytes [N_REQ];

   logic             locked;
   logic             g_valid;
   logic             g_last;
   logic             handshake;
   logic             pkt_done;
   logic             force_release;
   logic             release_now;
   logic [GW-1:0]    next_ptr;
   logic [GW-1:0]    pick_idx;
   logic [N_REQ-1:0] pick_oh;
   logic             pick_found;

   ladybird_rr_pick #(
      .N (N_REQ),
      .W (GW)
   ) u_pick (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .found  (pick_found)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_bytes[i] = req_data[8*i +: 8];
      end
   end

   // The owner's stream passes straight through; the transmitter's ready never
   // depends on valid, so this path cannot form a combinational loop.
   assign locked      = (state == ARB_LOCKED);
   assign busy        = locked;
   assign g_valid     = req_valid[grant_id];
   assign g_last      = req_last[grant_id];
   assign tx_valid    = locked & g_valid;
   assign tx_data     = req_bytes[grant_id];
   assign req_ready   = (locked && tx_ready) ? grant_oh : '0;
   assign handshake   = tx_valid & tx_ready;
   assign pkt_done    = handshake & g_last;
   assign next_ptr    = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);
   assign release_now = pkt_done | force_release;

`ifdef LADYBIRD_UART_ARB_TIMEOUT_EN
   logic [UART_ARB_TIMEOUT_W-1:0] stall_cnt;

   assign force_release = locked && (stall_cnt == IDLE_TIMEOUT);
   assign timeout       = force_release;

   // Counts owner-idle cycles; held at zero in IDLE so every grant starts fresh.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         stall_cnt <= '0;
      end else if (!locked || handshake || force_release) begin
         stall_cnt <= '0;
      end else if (!g_valid) begin
         stall_cnt <= stall_cnt + UART_ARB_TIMEOUT_W'(1);
      end
   end
`else
   assign force_release = 1'b0;
   assign timeout       = 1'b0;
`endif

   // Grant is taken in IDLE and held until the last byte is accepted (or the
   // owner is forced off); the pointer then moves past the departing owner.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         grant_oh <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  grant_oh <= pick_oh;
                  state    <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (release_now) begin
                  rr_ptr <= next_ptr;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ladybird_uart_tx_arbiter.sv
// Self-checking bench for ladybird_uart_tx_arbiter: queue-driven requesters, a
// packet-level ownership model checked every cycle, and literal log checks.
module tb_ladybird_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 8;
`ifdef LADYBIRD_UART_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           arst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic           tx_ready;
   logic [1:0]     grant_id;
   logic           busy;
   logic           timeout;

   ladybird_uart_tx_arbiter #(
      .N_REQ        (N),
      .IDLE_TIMEOUT (16'(TO))
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-requester byte queues: bit 8 is the last flag.
   logic [8:0]   mem [N][32];
   int           head [N];
   int           tail [N];
   logic [N-1:0] hold = '0;
   logic [N-1:0] accepted = '0;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = (head[i] < tail[i]) && !hold[i];
         req_data[8*i +: 8] = mem[i][5'(head[i])][7:0];
         req_last[i]        = mem[i][5'(head[i])][8];
      end
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (accepted[i]) head[i] = head[i] + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input int r, input logic [7:0] b, input logic last);
      mem[r][5'(tail[r])] = {last, b};
      tail[r] = tail[r] + 1;
   endtask

   // Ownership model: who owns the link, where the next search starts, how long
   // the owner has been silent.
   int         m_owner = -1;
   int         m_ptr   = 0;
   int         m_grant = 0;
   int         m_stall = 0;
   logic [7:0] tx_log [64];
   int         tx_cnt = 0;
   int         grant_log [64];
   int         g_cnt = 0;
   int         to_cnt = 0;
   logic       busy_q = 1'b0;

   always @(negedge clk) begin
      logic       e_busy, e_tv, e_to, hs, found;
      logic [3:0] e_rdy;
      int         o, j;
      if (arst) begin
         m_owner = -1; m_ptr = 0; m_grant = 0; m_stall = 0;
      end
      o      = m_owner;
      e_busy = (o >= 0);
      e_tv   = e_busy && req_valid[o];
      e_rdy  = (e_busy && tx_ready) ? 4'(1 << o) : 4'd0;
      e_to   = TO_EN && e_busy && (m_stall == TO);
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("tx_valid", 32'(tx_valid), 32'(e_tv));
      checkOutput("req_ready", 32'(req_ready), 32'(e_rdy));
      checkOutput("grant_id", 32'(grant_id), 32'(m_grant));
      checkOutput("timeout", 32'(timeout), 32'(e_to));
      if (e_tv) checkOutput("tx_data", 32'(tx_data), 32'(mem[o][5'(head[o])][7:0]));

      accepted = req_valid & req_ready;
      if (tx_valid && tx_ready && tx_cnt < 64) begin
         tx_log[tx_cnt] = tx_data;
         tx_cnt++;
      end
      if (busy && !busy_q && g_cnt < 64) begin
         grant_log[g_cnt] = int'(grant_id);
         g_cnt++;
      end
      busy_q = busy;
      if (timeout) to_cnt++;

      if (!arst) begin
         if (o < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (!found && req_valid[j]) begin
                  found = 1'b1; m_owner = j; m_grant = j; m_stall = 0;
               end
            end
         end else begin
            hs = req_valid[o] && tx_ready;
            if (e_to || (hs && req_last[o])) begin
               m_owner = -1;
               m_ptr   = (o + 1) % N;
               m_stall = 0;
            end else if (hs) begin
               m_stall = 0;
            end else if (!req_valid[o]) begin
               m_stall++;
            end
         end
      end
   end

   task automatic waitLog(input int n, input int limit);
      for (int c = 0; c < limit; c++) begin
         @(posedge clk);
         if (tx_cnt >= n) break;
      end
      #2;
      if (tx_cnt < n) checkOutput("wait_tx_log", 32'(tx_cnt), 32'(n));
   endtask

   initial begin
      int base, gbase, tbase;
      logic [7:0] exp6 [4];
      arst = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < N; i++) applyStimulus(i, 8'hA0 + 8'(i), 1'b1);
      for (int i = 0; i < N; i++) applyStimulus(i, 8'hB0 + 8'(i), 1'b1);

      // Reset with every requester asking, then the first grant and 4-way rotation
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      base = tx_cnt; gbase = g_cnt;
      @(posedge clk); #2 arst = 1'b0;
      @(negedge clk);
      checkOutput("arb_cycle_busy", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("first_grant_busy", 32'(busy), 32'd1);
      checkOutput("first_grant_id", 32'(grant_id), 32'd0);
      waitLog(base + 8, 200);
      for (int k = 0; k < 8; k++) begin
         checkOutput("rr_byte", 32'(tx_log[base + k]), (k < 4) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k - 4));
         checkOutput("rr_grant", 32'(grant_log[gbase + k]), 32'(k % 4));
      end

      // Packet from req0 runs contiguously before req1's waiting byte
      base = tx_cnt;
      applyStimulus(0, 8'h41, 1'b0);
      applyStimulus(0, 8'h42, 1'b0);
      applyStimulus(0, 8'h43, 1'b1);
      applyStimulus(1, 8'h55, 1'b1);
      waitLog(base + 4, 100);
      checkOutput("pkt_b0", 32'(tx_log[base]), 32'h41);
      checkOutput("pkt_b1", 32'(tx_log[base + 1]), 32'h42);
      checkOutput("pkt_b2", 32'(tx_log[base + 2]), 32'h43);
      checkOutput("pkt_b3", 32'(tx_log[base + 3]), 32'h55);

      // Transmitter back-pressure mid-packet
      base = tx_cnt;
      for (int k = 0; k < 4; k++) applyStimulus(2, 8'h60 + 8'(k), k == 3);
      waitLog(base + 2, 100);
      tx_ready = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("stall_tx_data", 32'(tx_data), 32'h62);
      checkOutput("stall_tx_valid", 32'(tx_valid), 32'd1);
      checkOutput("stall_grant", 32'(grant_id), 32'd2);
      repeat (10) @(negedge clk);
      @(posedge clk); #2 tx_ready = 1'b1;
      waitLog(base + 4, 100);
      for (int k = 0; k < 4; k++) checkOutput("stall_byte", 32'(tx_log[base + k]), 32'h60 + 32'(k));

      // Reset mid-packet abandons req2; pointer restarts at 0 so req1 wins
      base = tx_cnt;
      for (int k = 0; k < 4; k++) applyStimulus(2, 8'h70 + 8'(k), k == 3);
      waitLog(base + 2, 100);
      arst = 1'b1;
      @(negedge clk);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_tx_valid", 32'(tx_valid), 32'd0);
      checkOutput("arst_grant", 32'(grant_id), 32'd0);
      applyStimulus(1, 8'h80, 1'b1);
      @(posedge clk); #2 arst = 1'b0;
      base = tx_cnt;
      repeat (2) @(negedge clk);
      checkOutput("post_arst_grant", 32'(grant_id), 32'd1);
      waitLog(base + 3, 100);
      checkOutput("post_arst_b0", 32'(tx_log[base]), 32'h80);
      checkOutput("post_arst_b1", 32'(tx_log[base + 1]), 32'h72);
      checkOutput("post_arst_b2", 32'(tx_log[base + 2]), 32'h73);

      // Owner goes silent mid-packet
      base = tx_cnt; tbase = to_cnt;
      applyStimulus(3, 8'h90, 1'b0);
      applyStimulus(3, 8'h91, 1'b0);
      applyStimulus(3, 8'h92, 1'b1);
      waitLog(base + 1, 100);
      hold[3] = 1'b1;
      applyStimulus(0, 8'hA5, 1'b1);
      repeat (5) @(negedge clk);
      checkOutput("silent_busy", 32'(busy), 32'd1);
      checkOutput("silent_grant", 32'(grant_id), 32'd3);
      repeat (16) @(posedge clk);
      #2 hold[3] = 1'b0;
      waitLog(base + 4, 100);
`ifdef LADYBIRD_UART_ARB_TIMEOUT_EN
      exp6 = '{8'h90, 8'hA5, 8'h91, 8'h92};
`else
      exp6 = '{8'h90, 8'h91, 8'h92, 8'hA5};
`endif
      for (int k = 0; k < 4; k++) checkOutput("silent_byte", 32'(tx_log[base + k]), 32'(exp6[k]));
      checkOutput("timeout_pulses", 32'(to_cnt - tbase), TO_EN ? 32'd1 : 32'd0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
